// File: rtl/fifo_tx_arb.sv
// Two-port frame arbiter: round-robin at frame granularity, moving header + N payload words into one transmit FIFO.
// Optional FIFO_TX_ARB_TAG_EN: replaces the header MSB with the source port index.
module fifo_tx_arb #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din0,
   input  logic             empty0,
   output logic             rden0,
   input  logic [WIDTH-1:0] din1,
   input  logic             empty1,
   output logic             rden1,
   output logic [WIDTH-1:0] dout,
   output logic             wren,
   input  logic             full,
   output logic             grant,
   output logic             busy
);

   // state   | meaning
   // IDLE    | arbitrating; no strobes, grant holds last winner
   // HDR     | waiting to move the header word of the granted port
   // PAYLOAD | moving payload words, cnt = words still to move

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic             grant_nxt;
   logic             prio, prio_nxt;
   logic [WIDTH-1:0] din_sel;
   logic             empty_sel;
   logic             xfer;
   logic             pick;

   assign din_sel   = grant ? din1 : din0;
   assign empty_sel = grant ? empty1 : empty0;
   assign xfer      = (state != S_IDLE) && !empty_sel && !full;

   // prio is the tie winner; a lone non-empty port wins regardless
   assign pick = (!empty0 && !empty1) ? prio : empty0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         grant <= 1'b0;
         prio  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         grant <= grant_nxt;
         prio  <= prio_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant_nxt = grant;
      prio_nxt  = prio;
      case (state)
         S_IDLE: begin
            if (!empty0 || !empty1) begin
               grant_nxt = pick;
               prio_nxt  = ~pick;
               state_nxt = S_HDR;
            end
         end
         S_HDR: begin
            if (xfer) begin
               if (din_sel[7:0] == 8'd0) begin
                  state_nxt = S_IDLE;
               end else begin
                  cnt_nxt   = din_sel[7:0];
                  state_nxt = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (xfer) begin
               cnt_nxt = cnt - 8'd1;
               if (cnt == 8'd1) begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != S_IDLE);
      wren  = xfer;
      rden0 = xfer && !grant;
      rden1 = xfer && grant;
      dout  = din_sel;
`ifdef FIFO_TX_ARB_TAG_EN
      if (state == S_HDR) begin
         dout[WIDTH-1] = grant;
      end
`endif
   end

endmodule

// File: tb/tb_fifo_tx_arb.sv
// Directed bench for fifo_tx_arb: source FIFOs as queues, frame-level model checked every cycle.
module tb_fifo_tx_arb;

   localparam int WIDTH = 16;
`ifdef FIFO_TX_ARB_TAG_EN
   localparam logic [15:0] TAG_HDR = 16'h8002;
`else
   localparam logic [15:0] TAG_HDR = 16'h0002;
`endif

   logic             clk, rst_n;
   logic [WIDTH-1:0] din0, din1, dout;
   logic             empty0, empty1, rden0, rden1, wren, full, grant, busy;

   fifo_tx_arb #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .din0(din0), .empty0(empty0), .rden0(rden0),
      .din1(din1), .empty1(empty1), .rden1(rden1),
      .dout(dout), .wren(wren), .full(full),
      .grant(grant), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] q0[$], q1[$], out_log[$];
   int          hdr_port_log[$], wr_cyc[$];
   int          errors = 0, checks = 0, cyc = 0, rd1_cnt = 0;

   // frame-level model: is a frame open, which port, header pending, words left
   bit m_busy, m_port, m_hdr, m_prio;
   int m_left;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=completion", name);
   endtask

   task automatic model_reset();
      m_busy = 0; m_port = 0; m_hdr = 0; m_prio = 0; m_left = 0;
   endtask

   task automatic drive();
      din0   = (q0.size() > 0) ? q0[0] : 16'h0;
      din1   = (q1.size() > 0) ? q1[0] : 16'h0;
      empty0 = (q0.size() == 0);
      empty1 = (q1.size() == 0);
   endtask

   task automatic step(input logic f);
      logic        ex, rd0, rd1;
      logic [15:0] raw, expw;
      full = f;
      drive();
      @(negedge clk);
      cyc++;
      ex = m_busy && !(m_port ? empty1 : empty0) && !full;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant", 32'(grant), 32'(m_port));
      chk("wren", 32'(wren), 32'(ex));
      chk("rden0", 32'(rden0), 32'(ex && !m_port));
      chk("rden1", 32'(rden1), 32'(ex && m_port));
      raw = 16'h0;
      if (ex) begin
         raw  = m_port ? q1[0] : q0[0];
         expw = raw;
`ifdef FIFO_TX_ARB_TAG_EN
         if (m_hdr) expw[15] = m_port;
`endif
         chk("dout", 32'(dout), 32'(expw));
      end
      if (wren) begin
         out_log.push_back(dout);
         wr_cyc.push_back(cyc);
         if (m_hdr) hdr_port_log.push_back(int'(grant));
      end
      rd0 = rden0;
      rd1 = rden1;
      if (rd1) rd1_cnt++;
      if (!m_busy) begin
         if (!empty0 || !empty1) begin
            m_port = (!empty0 && !empty1) ? m_prio : empty0;
            m_prio = !m_port;
            m_busy = 1;
            m_hdr  = 1;
         end
      end else if (ex) begin
         if (m_hdr) begin
            m_hdr  = 0;
            m_left = int'(raw[7:0]);
            if (m_left == 0) m_busy = 0;
         end else begin
            m_left--;
            if (m_left == 0) m_busy = 0;
         end
      end
      @(posedge clk);
      #1;
      if (rd0 && q0.size() > 0) void'(q0.pop_front());
      if (rd1 && q1.size() > 0) void'(q1.pop_front());
   endtask

   task automatic run_idle(input string name, input int max);
      int n = 0;
      while ((m_busy || q0.size() > 0 || q1.size() > 0) && n < max) begin
         step(1'b0);
         n++;
      end
      if (n >= max) timeout(name);
      step(1'b0);
   endtask

   task automatic run_until_words(input string name, input int words, input int max);
      int n = 0;
      while (out_log.size() < words && n < max) begin
         step(1'b0);
         n++;
      end
      if (n >= max) timeout(name);
   endtask

   task automatic clear_logs();
      out_log.delete();
      hdr_port_log.delete();
      wr_cyc.delete();
      rd1_cnt = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      full  = 1'b0;
      model_reset();
      drive();
      #12;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_wren", 32'(wren), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      step(1'b0);

      // single frame on port 0
      clear_logs();
      q0 = '{16'h0003, 16'hA1A1, 16'hB2B2, 16'hC3C3};
      run_idle("t1_done", 30);
      chk("t1_words", 32'(out_log.size()), 32'd4);
      if (out_log.size() == 4) begin
         chk("t1_w0", 32'(out_log[0]), 32'h0003);
         chk("t1_w3", 32'(out_log[3]), 32'hC3C3);
         chk("t1_consec", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
      end

      // both ports loaded at reset release, then alternation
      rst_n = 1'b0;
      model_reset();
      clear_logs();
      q0 = '{16'h0001, 16'h1111};
      q1 = '{16'h0001, 16'h2222};
      drive();
      #3;
      chk("rst_rden0", 32'(rden0), 32'h0);
      chk("rst_rden1", 32'(rden1), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_idle("t2_done", 40);
      chk("t2_n", 32'(hdr_port_log.size()), 32'd2);
      if (hdr_port_log.size() == 2) begin
         chk("t2_first", 32'(hdr_port_log[0]), 32'd0);
         chk("t2_second", 32'(hdr_port_log[1]), 32'd1);
      end
      clear_logs();
      q0 = '{16'h0101, 16'h3333};
      step(1'b0);
      q1.push_back(16'h0001); q1.push_back(16'h4444);
      q0.push_back(16'h0001); q0.push_back(16'h5555);
      run_idle("t2b_done", 40);
      chk("t2b_n", 32'(hdr_port_log.size()), 32'd3);
      if (hdr_port_log.size() == 3) begin
         chk("t2b_p0", 32'(hdr_port_log[0]), 32'd0);
         chk("t2b_p1", 32'(hdr_port_log[1]), 32'd1);
         chk("t2b_p2", 32'(hdr_port_log[2]), 32'd0);
      end

      // downstream stall mid-frame
      clear_logs();
      q0 = '{16'h0005, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
      run_until_words("t3_pre", 3, 20);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         chk("t3_stall_grant", 32'(grant), 32'h0);
      end
      chk("t3_held", 32'(out_log.size()), 32'd3);
      run_idle("t3_done", 30);
      chk("t3_words", 32'(out_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < out_log.size(); i++)
         chk("t3_order", 32'(out_log[i]), 32'h0010 + 32'(i) - ((i == 0) ? 32'hB : 32'h1));

      // zero-length frame on port 1
      clear_logs();
      q1 = '{16'h0000};
      run_idle("t4_done", 10);
      chk("t4_words", 32'(out_log.size()), 32'd1);
      chk("t4_rden1", 32'(rd1_cnt), 32'd1);

      // reset in the middle of a payload
      clear_logs();
      q0 = '{16'h0006, 16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025};
      run_until_words("t5_pre", 3, 20);
      chk("t5_active", 32'(wren), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_wren", 32'(wren), 32'h0);
      chk("t5_rden0", 32'(rden0), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_grant", 32'(grant), 32'h0);
      q0.delete();
      q1.delete();
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      step(1'b0);
      clear_logs();

      // header tagging (or not) on port 1
      q1 = '{16'h0002, 16'h8001, 16'h0005};
      run_idle("t6_done", 20);
      chk("t6_words", 32'(out_log.size()), 32'd3);
      if (out_log.size() == 3) begin
         chk("t6_hdr", 32'(out_log[0]), 32'(TAG_HDR));
         chk("t6_p0", 32'(out_log[1]), 32'h8001);
         chk("t6_p1", 32'(out_log[2]), 32'h0005);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_tx_arb.md
FIFO_TX_ARB -- requirements
Module: fifo_tx_arb

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits; SHALL be >= 9.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 din0  input  WIDTH  port 0 FWFT FIFO head word, valid while empty0 is low.
REQ-005 empty0  input  1  port 0 source FIFO empty.
REQ-006 rden0  output  1  port 0 pop strobe; the head word is consumed on the rising edge where rden0 is high.
REQ-007 din1, empty1, rden1  input/input/output  WIDTH/1/1  port 1, identical semantics to port 0.
REQ-008 dout  output  WIDTH  word to the downstream transmit FIFO write port.
REQ-009 wren  output  1  downstream write strobe.
REQ-010 full  input  1  downstream FIFO full.
REQ-011 grant  output  1  index of the currently or last selected port.
REQ-012 busy  output  1  high while not in IDLE.

Function
REQ-013 Frame format: one header word, where bits [7:0] give payload length N (0..255), followed by N payload words; the upper header bits are opaque.
REQ-014 FSM states: IDLE, HDR, PAYLOAD.
REQ-015 IDLE: when either emptyX is low, the block SHALL latch grant to the chosen port and go to HDR on the next edge; otherwise it stays in IDLE.
REQ-016 Selection SHALL be round-robin at frame granularity.
  - The port not granted last wins a tie.
  - A lone non-empty port always wins.
REQ-017 Transfer condition xfer = (state HDR or PAYLOAD) AND NOT empty[grant] AND NOT full.
REQ-018 Strobes: rden[grant] = wren = xfer, combinational. The non-granted rden SHALL be 0. Both strobes SHALL be 0 in IDLE.
REQ-019 dout SHALL equal din[grant] combinationally, giving zero latency from FIFO head to write port, subject to REQ-029.
REQ-020 HDR with xfer, N=0: the next state SHALL be IDLE.
REQ-021 HDR with xfer, N>0: load an 8-bit counter with N and go to PAYLOAD.
REQ-022 PAYLOAD: each xfer decrements the counter; an xfer at count 1 SHALL return to IDLE.
REQ-023 Without xfer (source empty or downstream full), the FSM SHALL hold state and counter; mid-frame stalls SHALL NOT release grant.
REQ-024 Every frame incurs exactly one IDLE cycle of arbitration overhead; no word is ever written while full is high.

Reset
REQ-025 On rst_n low, the block SHALL immediately enter IDLE, including when asserted mid-frame.
REQ-026 During reset the following values SHALL hold:
  - counter = 0, grant = 0, busy = 0;
  - rden0 = rden1 = wren = 0;
  - round-robin pointer set so port 0 wins the first tie.
REQ-027 Words of a frame interrupted by reset are not resynchronised; upstream FIFOs SHALL be reset together with this block.

Configuration
REQ-028 Macro FIFO_TX_ARB_TAG_EN controls source tagging of header words.
REQ-029 With FIFO_TX_ARB_TAG_EN defined, in HDR state dout[WIDTH-1] SHALL be replaced by grant; all other bits and all payload words pass unchanged.
REQ-030 Without FIFO_TX_ARB_TAG_EN, dout SHALL equal din[grant] unmodified in all states.

Verification
REQ-031 Port 0 only: frame hdr 0x0003 + payload A,B,C, full=0 -> wren high 4 consecutive cycles, dout 0x0003,A,B,C, then busy=0 for 1 cycle.
REQ-032 Both ports hold a 1-payload frame at reset release -> port 0 frame first, then port 1; a second pair of frames -> port 1 wins (alternation).
REQ-033 Port 0 frame with N=5; full forced high for 3 cycles after the 2nd payload word -> wren=0 during the stall, grant stays 0, all 6 words delivered in order, no duplicates.
REQ-034 Header 0x0000 on port 1 -> a single wren cycle, FSM returns to IDLE, rden1 pulses exactly once.
REQ-035 rst_n pulsed low mid-PAYLOAD (count 4) -> rden0/wren drop asynchronously, busy=0, state IDLE, grant=0.
REQ-036 With FIFO_TX_ARB_TAG_EN, port 1 header 0x0002 at WIDTH=16 -> dout 0x8002; payload words unmodified. Without the macro -> dout 0x0002.
